cksum_ctrl: RTL and testbench
=============================

Name: cksum_ctrl

Overview:
Channel-mapped controller that sequences a byte-checksum datapath over a host-programmed block length. It sits on the comm_fpga channel read/write interface beside the other channel registers, and occupies six consecutive channel addresses. The host writes a length, issues start, streams bytes, polls status and reads back the result. The top level ORs f2hData_out with the other channel read muxes.

Parameters:
CHAN_BASE, 7'h00, first of six consecutive channel addresses: +0 data/status, +1 control, +2 len lo, +3 len hi, +4 sum lo, +5 sum hi.
LEN_W, 16, width of the length register and the remaining-byte counter.

Ports:
clk_in  in  1  system clock; all state changes on the rising edge.
reset_in  in  1  asynchronous, active-high reset.
chanAddr_in  in  7  currently selected channel.
h2fData_in  in  8  host write data.
h2fValid_in  in  1  host write strobe; a byte transfers on an edge where valid & ready & address hit.
h2fReady_out  out  1  1 whenever chanAddr_in is within the block's window; otherwise 0.
f2hData_out  out  8  read data for the selected channel; 8'h00 when chanAddr_in is outside the window.
f2hValid_out  out  1  1 when chanAddr_in is within the window; otherwise 0.
f2hReady_in  in  1  host read strobe; reads have no side effects, so this is used only for the read-clear of overrun.
checksum_out  out  16  live accumulator value, for the seven-seg display.
busy_out  out  1  1 in state RUN.
done_out  out  1  1 in state DONE.

Behaviour:
- Reset (async): state=IDLE; sum=0; len=0; remaining=0; overrun=0. All outputs derive from these registers; checksum_out=0, busy_out=0, done_out=0.
- States: IDLE, RUN, DONE.
- Control write (+1): bit1 = abort, bit0 = start; all other bits are ignored.
  - Abort (any state): go to IDLE; clear sum and overrun; len is retained. If abort and start are set together, abort wins.
  - Start from IDLE or DONE: clear sum and overrun; remaining<=len; next state is RUN, or DONE if len==0.
  - Start while in RUN: ignored.
- Length writes (+2, +3): update len[7:0] and len[15:8] in IDLE or DONE; ignored in RUN.
- Data write (+0) in RUN: sum<=sum+byte, modulo 2^16 with the carry out discarded; remaining<=remaining-1.
  - If remaining==1 at that edge, go to DONE on the same edge.
  - One byte per clock is sustained; no backpressure.
  - Result is visible on checksum_out in the cycle after the accepting edge.
- Data write (+0) in IDLE or DONE: the byte is dropped; overrun<=1 (sticky); sum is unchanged.
- Reads (combinational from registers):
  - +0 = {5'b0, overrun, done, busy}.
  - +1 = 8'h00.
  - +2 / +3 = len bytes.
  - +4 / +5 = sum bytes.
- Overrun is cleared by start, abort, or a +0 read handshake (f2hReady_in=1 on an edge with the address at +0).
- Simultaneous events at one edge are mutually exclusive, since only one chanAddr is active. The overrun set-vs-clear case cannot occur.
- Reset asserted mid-RUN: immediate return to reset values; any partially accumulated sum is lost.

Optional Feature:
CKSUM_FLETCHER_EN.
- Defined: the accumulator is Fletcher-16. Per byte: A=(A+byte) mod 255, then B=(B+A_new) mod 255, each computed as a 9-bit add followed by a conditional subtract of 255. sum={B,A}. Start/abort clear both A and B.
- Undefined: plain 16-bit additive sum as above.
- All other behaviour is identical in both builds.

Test Plan:
1. len=3 (+2=03, +3=00), start, write 01,02,03 -> busy for 3 transfers; status=0x02; sum=0x0006. With CKSUM_FLETCHER_EN: sum=0x0A06.
2. len=258, start, write 258 bytes of 0xFF -> sum=0x00FE (wrap); done_out=1 on the edge accepting the 258th byte.
3. len=0, start -> DONE on the next cycle, busy never seen, sum=0x0000.
4. In IDLE, write 0x55 to +0 -> status=0x04, sum unchanged. A read of +0 returns 0x04; the following read returns 0x00.
5. len=10, start, write 4 bytes, then control=0x03 (abort+start) -> IDLE, sum=0, len still 10. The next start goes to RUN with remaining=10.
6. Mid-RUN, pulse reset_in asynchronously between edges -> all outputs are 0 immediately; len reads back 0x0000.

Source files
------------

// File: rtl/cksum_ctrl_if.sv
// Channel read/write bus between the comm_fpga host side and a channel-mapped block.
// The host drives address, write data/strobe and read strobe; the block answers with
// write-ready, read data and read-valid.
interface cksum_ctrl_if;
    logic [6:0] chanAddr_in;
    logic [7:0] h2fData_in;
    logic       h2fValid_in;
    logic       h2fReady_out;
    logic [7:0] f2hData_out;
    logic       f2hValid_out;
    logic       f2hReady_in;

    modport master (
        output chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
        input  h2fReady_out, f2hData_out, f2hValid_out
    );

    modport slave (
        input  chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
        output h2fReady_out, f2hData_out, f2hValid_out
    );
endinterface

// File: rtl/cksum_ctrl.sv
// Channel-mapped byte-checksum controller occupying six channel addresses from CHAN_BASE:
// +0 data/status, +1 control, +2/+3 length, +4/+5 sum.
// Build option: define CKSUM_FLETCHER_EN for a Fletcher-16 accumulator instead of a
// plain 16-bit additive sum. LEN_W must be at least 16; only the low 16 bits are host-visible.
module cksum_ctrl #(
    parameter logic [6:0]  CHAN_BASE = 7'h00,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                clk_in,
    input  logic                reset_in,
    cksum_ctrl_if.slave         bus,
    output logic [15:0]         checksum_out,
    output logic                busy_out,
    output logic                done_out
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [15:0]      sum_q, sum_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             overrun_q, overrun_d;

    logic [6:0]       offset;
    logic             in_win;
    logic             wr_hit;
    logic             status_rd;
    logic [15:0]      sum_add;
    logic [15:0]      len_host;

    // Window decode; subtraction keeps the window contiguous even if it wraps the 7-bit space.
    always_comb begin
        offset    = bus.chanAddr_in - CHAN_BASE;
        in_win    = (offset < 7'd6);
        wr_hit    = in_win & bus.h2fValid_in;
        status_rd = in_win & bus.f2hReady_in & (offset == 7'd0);
        len_host  = 16'(len_q);
    end

    // Accumulator step for the byte currently on the write bus.
`ifdef CKSUM_FLETCHER_EN
    logic [8:0] a_add, b_add;
    logic [7:0] a_new, b_new;
    always_comb begin
        a_add   = {1'b0, sum_q[7:0]} + {1'b0, bus.h2fData_in};
        a_new   = (a_add >= 9'd255) ? 8'(a_add - 9'd255) : a_add[7:0];
        b_add   = {1'b0, sum_q[15:8]} + {1'b0, a_new};
        b_new   = (b_add >= 9'd255) ? 8'(b_add - 9'd255) : b_add[7:0];
        sum_add = {b_new, a_new};
    end
`else
    always_comb begin
        sum_add = sum_q + {8'h00, bus.h2fData_in};
    end
`endif

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        len_d     = len_q;
        rem_d     = rem_q;
        overrun_d = overrun_q;

        // Read-clear first so a coincident overrun set would win.
        if (status_rd) begin
            overrun_d = 1'b0;
        end

        if (wr_hit) begin
            case (offset)
                7'd0: begin
                    if (state_q == StRun) begin
                        sum_d = sum_add;
                        rem_d = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_d = StDone;
                        end
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                7'd1: begin
                    if (bus.h2fData_in[1]) begin
                        state_d   = StIdle;
                        sum_d     = 16'h0000;
                        overrun_d = 1'b0;
                    end else if (bus.h2fData_in[0] && (state_q != StRun)) begin
                        sum_d     = 16'h0000;
                        overrun_d = 1'b0;
                        rem_d     = len_q;
                        state_d   = (len_q == '0) ? StDone : StRun;
                    end
                end
                7'd2: begin
                    if (state_q != StRun) begin
                        len_d = LEN_W'({len_host[15:8], bus.h2fData_in});
                    end
                end
                7'd3: begin
                    if (state_q != StRun) begin
                        len_d = LEN_W'({bus.h2fData_in, len_host[7:0]});
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= StIdle;
            sum_q     <= 16'h0000;
            len_q     <= '0;
            rem_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            overrun_q <= overrun_d;
        end
    end

    // Read mux and handshake outputs; zero data outside the window so the top level can OR muxes.
    always_comb begin
        bus.f2hData_out = 8'h00;
        if (in_win) begin
            case (offset)
                7'd0:    bus.f2hData_out = {5'b0, overrun_q, (state_q == StDone), (state_q == StRun)};
                7'd2:    bus.f2hData_out = len_host[7:0];
                7'd3:    bus.f2hData_out = len_host[15:8];
                7'd4:    bus.f2hData_out = sum_q[7:0];
                7'd5:    bus.f2hData_out = sum_q[15:8];
                default: bus.f2hData_out = 8'h00;
            endcase
        end
        bus.h2fReady_out = in_win;
        bus.f2hValid_out = in_win;
        checksum_out     = sum_q;
        busy_out         = (state_q == StRun);
        done_out         = (state_q == StDone);
    end

endmodule

// File: tb/tb_cksum_ctrl.sv
// Scoreboard bench for cksum_ctrl: stimulus pushes expectations, a negedge monitor compares.
module tb_cksum_ctrl;

`ifdef CKSUM_FLETCHER_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct {
        string       name;
        int          kind;   // 0: read data, 1: {busy,done,checksum}, 2: {h2fReady,f2hValid,f2hData}
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cksum;
    logic        busy;
    logic        done;

    exp_t rd_q[$];
    exp_t side_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cksum_ctrl_if bus ();

    cksum_ctrl #(
        .CHAN_BASE (7'h00),
        .LEN_W     (16)
    ) dut (
        .clk_in       (clk),
        .reset_in     (rst),
        .bus          (bus),
        .checksum_out (cksum),
        .busy_out     (busy),
        .done_out     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compares on every read handshake and on every pending pin expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (bus.f2hValid_out && bus.f2hReady_in) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", {24'h0, bus.f2hData_out}, 32'hFFFF_FFFF);
            end else begin
                e = rd_q.pop_front();
                check(e.name, {24'h0, bus.f2hData_out}, e.exp);
            end
        end
        while (side_q.size() > 0) begin
            e = side_q.pop_front();
            if (e.kind == 1) act = {14'h0, busy, done, cksum};
            else             act = {22'h0, bus.h2fReady_out, bus.f2hValid_out, bus.f2hData_out};
            check(e.name, act, e.exp);
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        bus.chanAddr_in = a;
        bus.h2fData_in  = d;
        bus.h2fValid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.h2fValid_in = 1'b0;
    endtask

    task automatic rd(input string name, input logic [6:0] a, input logic [7:0] exp);
        exp_t e;
        e.name = name; e.kind = 0; e.exp = {24'h0, exp};
        rd_q.push_back(e);
        bus.chanAddr_in = a;
        bus.f2hReady_in = 1'b1;
        @(posedge clk);
        #1;
        bus.f2hReady_in = 1'b0;
    endtask

    task automatic push_st(input string name, input logic b, input logic dn, input logic [15:0] s);
        exp_t e;
        e.name = name; e.kind = 1; e.exp = {14'h0, b, dn, s};
        side_q.push_back(e);
    endtask

    task automatic probe_st(input string name, input logic b, input logic dn, input logic [15:0] s);
        push_st(name, b, dn, s);
        @(posedge clk);
        #1;
    endtask

    task automatic probe_bus(input string name, input logic [6:0] a, input logic rdy,
                             input logic vld, input logic [7:0] d);
        exp_t e;
        bus.chanAddr_in = a;
        e.name = name; e.kind = 2; e.exp = {22'h0, rdy, vld, d};
        side_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst             = 1'b1;
        bus.chanAddr_in = 7'h00;
        bus.h2fData_in  = 8'h00;
        bus.h2fValid_in = 1'b0;
        bus.f2hReady_in = 1'b0;
        @(posedge clk);
        #1;
        probe_st("reset_pins", 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        rd("reset_status", 7'h00, 8'h00);
        rd("reset_len_lo", 7'h02, 8'h00);

        // 1: len=3, bytes 01 02 03
        wr(7'h02, 8'h03);
        wr(7'h03, 8'h00);
        wr(7'h01, 8'h01);
        probe_st("t1_start", 1'b1, 1'b0, 16'h0000);
        wr(7'h00, 8'h01);
        probe_st("t1_b1", 1'b1, 1'b0, FL ? 16'h0101 : 16'h0001);
        wr(7'h00, 8'h02);
        wr(7'h00, 8'h03);
        probe_st("t1_done", 1'b0, 1'b1, FL ? 16'h0A06 : 16'h0006);
        rd("t1_status", 7'h00, 8'h02);
        rd("t1_sum_lo", 7'h04, 8'h06);
        rd("t1_sum_hi", 7'h05, FL ? 8'h0A : 8'h00);
        rd("t1_len_lo", 7'h02, 8'h03);
        rd("t1_ctrl", 7'h01, 8'h00);
        probe_bus("win_in", 7'h04, 1'b1, 1'b1, 8'h06);
        probe_bus("win_out_10", 7'h10, 1'b0, 1'b0, 8'h00);
        probe_bus("win_out_06", 7'h06, 1'b0, 1'b0, 8'h00);
        wr(7'h10, 8'hAA);
        wr(7'h12, 8'hAA);
        rd("outwin_status", 7'h00, 8'h02);
        rd("outwin_len_lo", 7'h02, 8'h03);

        // 2: len=258 of 0xFF, wraps
        wr(7'h02, 8'h02);
        wr(7'h03, 8'h01);
        wr(7'h01, 8'h01);
        for (int i = 0; i < 257; i++) wr(7'h00, 8'hFF);
        probe_st("t2_b257", 1'b1, 1'b0, FL ? 16'h0000 : 16'hFFFF);
        wr(7'h00, 8'hFF);
        probe_st("t2_done", 1'b0, 1'b1, FL ? 16'h0000 : 16'h00FE);
        rd("t2_sum_lo", 7'h04, FL ? 8'h00 : 8'hFE);
        rd("t2_len_hi", 7'h03, 8'h01);

        // 3: len=0 goes straight to DONE
        wr(7'h02, 8'h00);
        wr(7'h03, 8'h00);
        wr(7'h01, 8'h01);
        probe_st("t3_done", 1'b0, 1'b1, 16'h0000);
        rd("t3_status", 7'h00, 8'h02);

        // 4: overrun in IDLE, read-clear
        wr(7'h01, 8'h02);
        probe_st("t4_idle", 1'b0, 1'b0, 16'h0000);
        wr(7'h00, 8'h55);
        probe_st("t4_drop", 1'b0, 1'b0, 16'h0000);
        rd("t4_status_ovr", 7'h00, 8'h04);
        rd("t4_status_clr", 7'h00, 8'h00);
        rd("t4_sum_lo", 7'h04, 8'h00);

        // 5: abort+start mid-RUN, then full rerun of 10 bytes
        wr(7'h02, 8'h0A);
        wr(7'h03, 8'h00);
        wr(7'h01, 8'h01);
        for (int i = 1; i <= 4; i++) wr(7'h00, 8'(i));
        probe_st("t5_b4", 1'b1, 1'b0, FL ? 16'h140A : 16'h000A);
        wr(7'h02, 8'h77);
        wr(7'h01, 8'h03);
        probe_st("t5_abort", 1'b0, 1'b0, 16'h0000);
        rd("t5_len_lo", 7'h02, 8'h0A);
        rd("t5_len_hi", 7'h03, 8'h00);
        rd("t5_status", 7'h00, 8'h00);
        wr(7'h01, 8'h01);
        for (int i = 0; i < 5; i++) wr(7'h00, 8'h01);
        wr(7'h01, 8'h01);
        for (int i = 0; i < 4; i++) wr(7'h00, 8'h01);
        probe_st("t5_b9", 1'b1, 1'b0, FL ? 16'h2D09 : 16'h0009);
        wr(7'h00, 8'h01);
        probe_st("t5_done", 1'b0, 1'b1, FL ? 16'h370A : 16'h000A);

        // 6: async reset mid-RUN
        wr(7'h02, 8'h05);
        wr(7'h03, 8'h00);
        wr(7'h01, 8'h01);
        wr(7'h00, 8'h07);
        wr(7'h00, 8'h08);
        probe_st("t6_run", 1'b1, 1'b0, FL ? 16'h160F : 16'h000F);
        bus.chanAddr_in = 7'h02;
        push_st("t6_rst_pins", 1'b0, 1'b0, 16'h0000);
        e.name = "t6_rst_len_bus"; e.kind = 2; e.exp = {22'h0, 1'b1, 1'b1, 8'h00};
        side_q.push_back(e);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rd("t6_len_lo", 7'h02, 8'h00);
        rd("t6_len_hi", 7'h03, 8'h00);
        rd("t6_sum_lo", 7'h04, 8'h00);
        rd("t6_status", 7'h00, 8'h00);
        probe_st("t6_after", 1'b0, 1'b0, 16'h0000);

        repeat (3) @(posedge clk);
        if (rd_q.size() != 0)   check("rd_q_drained", rd_q.size(), 32'h0);
        if (side_q.size() != 0) check("side_q_drained", side_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
